// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - character screen buffer with cursor, newline, backspace and scroll
module text_buffer_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int CW   = 7
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          key_ready,
    input  logic [CW-1:0] rd_col,
    input  logic [CW-1:0] rd_row,
    output logic [7:0]    rd_ascii,
    output logic [CW-1:0] cursor_col,
    output logic [CW-1:0] cursor_row,
    output logic          busy
);

    localparam int TOTAL = ROWS * COLS;
    localparam int AW    = $clog2(TOTAL);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sweep_addr_q, sweep_addr_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [CW-1:0] top_row_q, top_row_d;
    logic [CW-1:0] cursor_col_q, cursor_col_d;
    logic [CW-1:0] cursor_row_q, cursor_row_d;
    logic [7:0]    rd_ascii_q, rd_ascii_d;
    logic          key_ready_q, key_ready_d;
    logic          busy_q, busy_d;

    logic [7:0]    mem [TOTAL];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          do_nl;
    logic [AW-1:0] rd_addr;
    logic          rd_in_range;

    // Screen row is rotated by top_row so scrolling never moves stored data.
    function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] row,
                                                input logic [CW-1:0] col,
                                                input logic [CW-1:0] top);
        logic [CW:0] phys;
        phys = {1'b0, top} + {1'b0, row};
        if (phys >= (CW+1)'(ROWS)) phys = phys - (CW+1)'(ROWS);
        return AW'(phys) * AW'(COLS) + AW'(col);
    endfunction

    always_comb begin
        rd_in_range = (rd_col < CW'(COLS)) && (rd_row < CW'(ROWS));
        rd_addr     = cell_addr(rd_row, rd_col, top_row_q);
        rd_ascii_d  = rd_in_range ? mem[rd_addr] : 8'h00;
    end

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        line_cnt_d   = line_cnt_q;
        top_row_d    = top_row_q;
        cursor_col_d = cursor_col_q;
        cursor_row_d = cursor_row_q;
        we           = 1'b0;
        waddr        = sweep_addr_q;
        wdata        = 8'h00;
        do_nl        = 1'b0;
        case (state_q)
            CLR_ALL: begin
                we = 1'b1;
                if (sweep_addr_q == AW'(TOTAL - 1)) begin
                    state_d      = IDLE;
                    sweep_addr_d = '0;
                end else begin
                    sweep_addr_d = sweep_addr_q + AW'(1);
                end
            end
            CLR_LINE: begin
                we = 1'b1;
                if (line_cnt_q == CW'(COLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    sweep_addr_d = sweep_addr_q + AW'(1);
                    line_cnt_d   = line_cnt_q + CW'(1);
                end
            end
            default: begin
                if (key_valid && key_ready_q) begin
                    if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cell_addr(cursor_row_q, cursor_col_q, top_row_q);
                        wdata = key_ascii;
                        if (cursor_col_q == CW'(COLS - 1)) do_nl = 1'b1;
                        else cursor_col_d = cursor_col_q + CW'(1);
                    end else if (key_ascii == 8'h0D || key_ascii == 8'h0A) begin
                        do_nl = 1'b1;
                    end else if (key_ascii == 8'h08) begin
                        if (cursor_col_q != '0) begin
                            cursor_col_d = cursor_col_q - CW'(1);
                            we           = 1'b1;
                            waddr        = cell_addr(cursor_row_q, cursor_col_q - CW'(1), top_row_q);
                        end else if (cursor_row_q != '0) begin
                            cursor_row_d = cursor_row_q - CW'(1);
                            cursor_col_d = CW'(COLS - 1);
                            we           = 1'b1;
                            waddr        = cell_addr(cursor_row_q - CW'(1), CW'(COLS - 1), top_row_q);
                        end
                    end
                end
                if (do_nl) begin
                    cursor_col_d = '0;
                    if (cursor_row_q < CW'(ROWS - 1)) begin
                        cursor_row_d = cursor_row_q + CW'(1);
                    end else begin
                        // Old top row becomes the new bottom row and must be blanked.
                        top_row_d    = (top_row_q == CW'(ROWS - 1)) ? '0 : top_row_q + CW'(1);
                        sweep_addr_d = AW'(top_row_q) * AW'(COLS);
                        line_cnt_d   = '0;
                        state_d      = CLR_LINE;
                    end
                end
            end
        endcase
        key_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CLR_ALL;
            sweep_addr_q <= '0;
            line_cnt_q   <= '0;
            top_row_q    <= '0;
            cursor_col_q <= '0;
            cursor_row_q <= '0;
            rd_ascii_q   <= 8'h00;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            line_cnt_q   <= line_cnt_d;
            top_row_q    <= top_row_d;
            cursor_col_q <= cursor_col_d;
            cursor_row_q <= cursor_row_d;
            rd_ascii_q   <= rd_ascii_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign rd_ascii   = rd_ascii_q;
    assign cursor_col = cursor_col_q;
    assign cursor_row = cursor_row_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - scoreboard bench for text_buffer_ctrl
module tb_text_buffer_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int CW   = 7;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          key_valid = 1'b0;
    logic [7:0]    key_ascii = 8'h00;
    logic          key_ready;
    logic [CW-1:0] rd_col = '0;
    logic [CW-1:0] rd_row = '0;
    logic [7:0]    rd_ascii;
    logic [CW-1:0] cursor_col;
    logic [CW-1:0] cursor_row;
    logic          busy;

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_ascii(key_ascii),
        .key_ready(key_ready), .rd_col(rd_col), .rd_row(rd_row), .rd_ascii(rd_ascii),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        int         r;
        int         c;
    } rd_exp_t;

    rd_exp_t    sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       rd_en = 1'b0;
    logic       rd_en_d = 1'b0;
    logic [7:0] scr [ROWS][COLS];
    int         mr = 0;
    int         mc = 0;

    always @(posedge clk) rd_en_d <= rd_en;

    always @(negedge clk) begin
        if (rd_en_d) begin
            rd_exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got %02h with empty scoreboard", rd_ascii);
            end else begin
                e = sb.pop_front();
                if (rd_ascii !== e.exp) begin
                    errors++;
                    $display("FAIL rd(%0d,%0d) got %02h expected %02h", e.r, e.c, rd_ascii, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_nl();
        mc = 0;
        if (mr < ROWS - 1) mr++;
        else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
        end
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            scr[mr][mc] = k;
            if (mc == COLS - 1) model_nl();
            else mc++;
        end else if (k == 8'h0D || k == 8'h0A) begin
            model_nl();
        end else if (k == 8'h08) begin
            if (mc > 0) begin
                mc--;
                scr[mr][mc] = 8'h00;
            end else if (mr > 0) begin
                mr--;
                mc = COLS - 1;
                scr[mr][mc] = 8'h00;
            end
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        int n = 0;
        key_valid = 1'b1;
        key_ascii = k;
        while (!key_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("FAIL key_ready_timeout got 0 expected 1");
            key_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(k);
    endtask

    task automatic chk_cursor(input string name, input int er, input int ec);
        chk({name, "_row"}, int'(cursor_row), er);
        chk({name, "_col"}, int'(cursor_col), ec);
    endtask

    task automatic rd_cell(input int r, input int c, input logic [7:0] e);
        rd_exp_t x;
        x.exp = e; x.r = r; x.c = c;
        rd_row = CW'(r);
        rd_col = CW'(c);
        rd_en  = 1'b1;
        sb.push_back(x);
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic read_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) rd_cell(r, c, scr[r][c]);
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        int not_busy = 0;
        while (!key_ready && n < 5000) begin
            if (!busy) not_busy++;
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_len"}, n, 2100);
        chk({name, "_busy_held"}, not_busy, 0);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_key_ready"}, int'(key_ready), 0);
        chk({name, "_rd_ascii"}, int'(rd_ascii), 0);
        chk_cursor(name, 0, 0);
    endtask

    initial begin
        int n;
        int not_busy;
        model_clear();

        #2 resetn = 1'b0;
        #1 chk_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        wait_sweep("sweep0");
        rd_cell(0, 0, 8'h00);
        rd_cell(29, 69, 8'h00);
        rd_cell(15, 33, 8'h00);

        send_key(8'h41);
        send_key(8'h42);
        chk_cursor("ab", 0, 2);
        rd_cell(0, 0, 8'h41);
        rd_cell(0, 1, 8'h42);
        rd_cell(0, 2, 8'h00);

        send_key(8'h08);
        send_key(8'h08);
        chk_cursor("bs_home", 0, 0);
        for (int i = 0; i < COLS; i++) send_key(8'h41);
        chk_cursor("line_wrap", 1, 0);
        rd_cell(0, 69, 8'h41);
        send_key(8'h08);
        chk_cursor("bs_up", 0, 69);
        rd_cell(0, 69, 8'h00);
        rd_cell(0, 68, 8'h41);
        for (int i = 0; i < COLS - 1; i++) send_key(8'h08);
        chk_cursor("bs_col0", 0, 0);
        send_key(8'h08);
        chk_cursor("bs_origin", 0, 0);
        send_key(8'h07);
        chk_cursor("ignored_code", 0, 0);
        rd_cell(0, 0, 8'h00);

        send_key(8'h5A);
        send_key(8'h0D);
        send_key(8'h51);
        send_key(8'h52);
        for (int i = 0; i < 28; i++) send_key(8'h0D);
        chk_cursor("bottom", 29, 0);
        rd_cell(0, 0, 8'h5A);
        rd_cell(1, 0, 8'h51);

        key_valid = 1'b1;
        key_ascii = 8'h0D;
        @(posedge clk); #1;
        model_key(8'h0D);
        key_ascii = 8'h41;
        chk_cursor("scroll", 29, 0);
        n = 0;
        not_busy = 0;
        while (!key_ready && n < 500) begin
            if (!busy) not_busy++;
            @(posedge clk); #1;
            n++;
        end
        chk("clr_line_len", n, 70);
        chk("clr_line_busy_held", not_busy, 0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_key(8'h41);
        chk_cursor("held_key", 29, 1);
        @(posedge clk); @(posedge clk); #1;
        chk_cursor("held_key_once", 29, 1);
        rd_cell(0, 0, 8'h51);
        rd_cell(0, 1, 8'h52);
        rd_cell(29, 0, 8'h41);
        rd_cell(29, 1, 8'h00);
        read_screen();

        for (int i = 0; i < ROWS; i++) begin
            send_key(8'h30 + 8'(i % 10));
            send_key(8'h0D);
        end
        send_key(8'h7E);
        chk_cursor("wrap_top", 29, 1);
        rd_cell(29, 0, 8'h7E);
        rd_cell(28, 0, 8'h39);
        rd_cell(0, 70, 8'h00);
        rd_cell(30, 0, 8'h00);
        read_screen();

        send_key(8'h0D);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_clr_busy", int'(busy), 1);
        resetn = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        model_clear();
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_sweep("sweep1");
        read_screen();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
Clocked character-buffer manager between the keyboard lookup stage and the VGA character/font stage. It accepts ASCII codes over a valid/ready handshake and keeps a ROWS x COLS screen buffer with a cursor. It handles printable writes, newline, backspace and scrolling. It also gives the VGA fetch path a registered read port addressed in screen coordinates.

Parameters:
COLS, 70, characters per row
ROWS, 30, rows per screen
CW, 7, width of column/row indices (must hold max(COLS,ROWS)-1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
key_valid  in  1  ASCII code available
key_ascii  in  8  ASCII code from lookup stage
key_ready  out  1  block can accept a code this cycle
rd_col  in  CW  screen column requested by VGA fetch
rd_row  in  CW  screen row requested by VGA fetch
rd_ascii  out  8  character at (rd_row, rd_col), one cycle later
cursor_col  out  CW  current cursor column
cursor_row  out  CW  current cursor screen row
busy  out  1  clear sweep in progress

Behaviour:
- Reset (resetn low, async): state=CLR_ALL, sweep_addr=0, top_row=0, cursor_col=0, cursor_row=0, rd_ascii=0x00, key_ready=0, busy=1.
- Storage: ROWS*COLS x 8-bit array, one write port, one synchronous read port.
- Physical row = (top_row + screen_row) mod ROWS.
- Address = phys_row*COLS + col.
- Read port: rd_ascii is registered from (rd_row, rd_col) sampled at the previous edge. Latency is 1 cycle in every state.
- While a clear sweep is running, a read of a not-yet-cleared cell returns the stale or X-free current value. Reads never stall.
- Out-of-range rd_col >= COLS or rd_row >= ROWS returns 0x00.
- FSM states:
  - CLR_ALL: writes 0x00 to sweep_addr and increments it each cycle. After address ROWS*COLS-1 it goes to IDLE. Takes ROWS*COLS cycles.
  - IDLE: key_ready=1, busy=0. A handshake (key_valid & key_ready) is processed in the same edge as follows:
    - Printable 0x20..0x7E: write the char at the cursor, then cursor_col+1. If cursor_col was COLS-1, do a NEWLINE instead of the increment.
    - 0x0D or 0x0A: NEWLINE.
    - 0x08 (backspace): if cursor_col>0, cursor_col-1 and write 0x00 at the new position. If cursor_col==0 and cursor_row>0, move to (cursor_row-1, COLS-1) and write 0x00 there. At (0,0), no change.
    - Any other code: consumed and ignored, no state change.
  - NEWLINE: cursor_col=0.
    - If cursor_row<ROWS-1: cursor_row+1, stay in IDLE.
    - If cursor_row==ROWS-1 (scroll): top_row=(top_row+1) mod ROWS, cursor_row stays ROWS-1, go to CLR_LINE.
  - CLR_LINE: key_ready=0, busy=1. Writes 0x00 to columns 0..COLS-1 of the new bottom screen row (physical row = old top_row), one per cycle. Takes COLS cycles, then returns to IDLE.
- key_ready is a registered/state-decoded output: 1 only in IDLE. A code presented while key_ready=0 is held by the upstream stage (valid stays high) and is not lost.
- Only one code is consumed per cycle. Back-to-back handshakes in IDLE are accepted every cycle.
- top_row wraps from ROWS-1 to 0.
- cursor_row and cursor_col never exceed ROWS-1 and COLS-1.
- Reset mid-operation: an async return to the reset values restarts CLR_ALL. A partially cleared line is covered by the full sweep.
- Arithmetic: address math is done at a width of at least clog2(ROWS*COLS). The mod ROWS is done by compare-and-subtract, with no divider.

Test Plan:
- Release resetn, hold key_valid=0 -> busy=1 and key_ready=0 for 2100 cycles, then key_ready=1. Any rd_ascii read returns 0x00.
- Send 'A'(0x41) then 'B'(0x42) on consecutive cycles -> cursor_col=2. Read (0,0) gives 0x41 and (0,1) gives 0x42, each valid 1 cycle after the address.
- Send 70 x 0x41 from (0,0) -> cursor=(1,0). Send 0x08 -> cursor=(0,69) and (0,69) reads 0x00. Send 0x08 at (0,0) -> no change.
- Send 0x0D 29 times with a 'Z' written on row 0 first, then one more 0x0D:
  - busy=1 and key_ready=0 for exactly 70 cycles.
  - Afterwards screen row 0 shows the old row 1 and row 29 reads all 0x00.
  - cursor=(29,0).
- Hold key_valid=1 with 0x41 during CLR_LINE -> the code is accepted on the first IDLE cycle only, written exactly once at (29,0).
- Assert resetn low midway through CLR_LINE -> outputs return to their reset values immediately (async), and a full 2100-cycle sweep follows.
